// File: rtl/ahb_cmd_sequencer_if.sv
// rtl/ahb_cmd_sequencer_if.sv - command/response streams plus AHB-lite master bus of the sequencer
interface ahb_cmd_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_write;
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  Hreadyout, Hresp, Hrdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write,
    output Haddr, Htrans, Hwrite, Hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output Hreadyout, Hresp, Hrdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write,
    input  Haddr, Htrans, Hwrite, Hwdata
  );
endinterface

// File: rtl/ahb_cmd_sequencer.sv
// rtl/ahb_cmd_sequencer.sv - AHB-lite master issuing queued single NONSEQ transfers with in-order responses
module ahb_cmd_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  ahb_cmd_sequencer_if.master bus,
  input  logic                err_clr,
  output logic                timeout_err,
  output logic                busy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_DATA = 2'd1,
    DP_ERR  = 2'd2
  } dp_state_t;

  logic [ADDR_W-1:0] r_cmd_addr  [DEPTH];
  logic [DATA_W-1:0] r_cmd_wdata [DEPTH];
  logic [DEPTH-1:0]  r_cmd_write;
  logic [PTR_W-1:0]  r_cmd_wr_ptr;
  logic [PTR_W-1:0]  r_cmd_rd_ptr;
  logic [CNT_W-1:0]  r_cmd_count;

  logic [DATA_W-1:0] r_rsp_rdata [DEPTH];
  logic [DEPTH-1:0]  r_rsp_err;
  logic [DEPTH-1:0]  r_rsp_write;
  logic [PTR_W-1:0]  r_rsp_wr_ptr;
  logic [PTR_W-1:0]  r_rsp_rd_ptr;
  logic [CNT_W-1:0]  r_rsp_count;

  dp_state_t         r_dp_state;
  dp_state_t         w_dp_next;
  logic              r_dph_write;
  logic [DATA_W-1:0] r_dph_wdata;
  logic [TO_W-1:0]   r_to_count;
  logic              r_timeout_err;

  logic              w_cmd_push;
  logic              w_head_valid;
  logic              w_dph_valid;
  logic              w_err_q;
  logic [CNT_W:0]    w_outstanding;
  logic              w_issue;
  logic              w_accept;
  logic              w_complete;
  logic              w_rsp_valid;
  logic              w_rsp_pop;
  logic              w_stall;

  assign w_cmd_push   = bus.cmd_valid && bus.cmd_ready;
  assign w_head_valid = (r_cmd_count != '0);
  assign w_rsp_valid  = (r_rsp_count != '0);
  assign w_rsp_pop    = w_rsp_valid && bus.rsp_ready;

  // Credit counts the in-flight data phase as well as queued responses, so the
  // response FIFO always has a slot for every transfer the bus has accepted.
  always_comb begin
    w_outstanding = {1'b0, r_rsp_count} + {{CNT_W{1'b0}}, w_dph_valid};
    w_issue       = w_head_valid && !w_err_q && (w_outstanding < CREDIT_MAX);
    w_accept      = w_issue && bus.Hreadyout;
    w_complete    = w_dph_valid && bus.Hreadyout;
    w_stall       = w_dph_valid && !bus.Hreadyout;
  end

  // Command FIFO
  always_ff @(posedge Hclk) begin
    if (w_cmd_push) begin
      r_cmd_addr[r_cmd_wr_ptr]  <= bus.cmd_addr;
      r_cmd_wdata[r_cmd_wr_ptr] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_cmd_write  <= '0;
      r_cmd_wr_ptr <= '0;
      r_cmd_rd_ptr <= '0;
      r_cmd_count  <= '0;
    end else begin
      if (w_cmd_push) begin
        r_cmd_write[r_cmd_wr_ptr] <= bus.cmd_write;
        r_cmd_wr_ptr              <= r_cmd_wr_ptr + 1'b1;
      end
      if (w_accept) begin
        r_cmd_rd_ptr <= r_cmd_rd_ptr + 1'b1;
      end
      case ({w_cmd_push, w_accept})
        2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
        2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // Data-phase tracker: DP_ERR is the second cycle of a two-cycle ERROR,
  // during which the address phase is withdrawn.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_dp_state <= DP_IDLE;
    end else begin
      r_dp_state <= w_dp_next;
    end
  end

  always_comb begin
    w_dp_next   = r_dp_state;
    w_dph_valid = (r_dp_state != DP_IDLE);
    w_err_q     = (r_dp_state == DP_ERR);
    case (r_dp_state)
      DP_IDLE: begin
        if (w_accept) begin
          w_dp_next = DP_DATA;
        end
      end
      DP_DATA, DP_ERR: begin
        if (bus.Hreadyout) begin
          w_dp_next = w_accept ? DP_DATA : DP_IDLE;
        end else if (bus.Hresp == HRESP_ERROR) begin
          w_dp_next = DP_ERR;
        end else begin
          w_dp_next = DP_DATA;
        end
      end
      default: w_dp_next = DP_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_dph_write <= 1'b0;
      r_dph_wdata <= '0;
    end else if (w_accept) begin
      r_dph_write <= r_cmd_write[r_cmd_rd_ptr];
      r_dph_wdata <= r_cmd_wdata[r_cmd_rd_ptr];
    end
  end

  // Response FIFO
  always_ff @(posedge Hclk) begin
    if (w_complete) begin
      r_rsp_rdata[r_rsp_wr_ptr] <= r_dph_write ? '0 : bus.Hrdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_rsp_err    <= '0;
      r_rsp_write  <= '0;
      r_rsp_wr_ptr <= '0;
      r_rsp_rd_ptr <= '0;
      r_rsp_count  <= '0;
    end else begin
      if (w_complete) begin
        r_rsp_err[r_rsp_wr_ptr]   <= (bus.Hresp == HRESP_ERROR);
        r_rsp_write[r_rsp_wr_ptr] <= r_dph_write;
        r_rsp_wr_ptr              <= r_rsp_wr_ptr + 1'b1;
      end
      if (w_rsp_pop) begin
        r_rsp_rd_ptr <= r_rsp_rd_ptr + 1'b1;
      end
      case ({w_complete, w_rsp_pop})
        2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
        2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
        default: r_rsp_count <= r_rsp_count;
      endcase
    end
  end

  // Hung-slave watchdog; err_clr wins over a same-cycle saturation.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_to_count    <= '0;
      r_timeout_err <= 1'b0;
    end else if (err_clr) begin
      r_to_count    <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_stall) begin
      if (r_to_count != TO_MAX) begin
        r_to_count <= r_to_count + 1'b1;
      end
      if (r_to_count >= TO_LAST) begin
        r_timeout_err <= 1'b1;
      end
    end else begin
      r_to_count <= '0;
    end
  end

  assign bus.cmd_ready = (r_cmd_count != FIFO_FULL);
  assign bus.Htrans    = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.Haddr     = w_issue ? r_cmd_addr[r_cmd_rd_ptr] : '0;
  assign bus.Hwrite    = w_issue && r_cmd_write[r_cmd_rd_ptr];
  assign bus.Hwdata    = (w_dph_valid && r_dph_write) ? r_dph_wdata : '0;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? r_rsp_rdata[r_rsp_rd_ptr] : '0;
  assign bus.rsp_err   = w_rsp_valid && r_rsp_err[r_rsp_rd_ptr];
  assign bus.rsp_write = w_rsp_valid && r_rsp_write[r_rsp_rd_ptr];
  assign timeout_err   = r_timeout_err;
  assign busy          = w_head_valid || w_dph_valid;
endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb/tb_ahb_cmd_sequencer.sv - randomized scoreboard bench with a behavioural AHB slave for ahb_cmd_sequencer
module tb_ahb_cmd_sequencer;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  logic err_clr = 1'b0;
  logic timeout_err;
  logic busy;

  ahb_cmd_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_cmd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .bus(bus),
    .err_clr(err_clr),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 Hclk = ~Hclk;

  typedef struct { logic [31:0] rdata; logic err; logic write; } rsp_t;
  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; } xfer_t;

  rsp_t  exp_q[$];
  xfer_t bus_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int n_vec = 0;
  int n_bad = 0;
  int rsp_mode = 1;
  int fixed_waits = -1;
  bit force_stall = 0;
  int n_accepted = 0;
  int cyc = 0;
  int acc_times[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  function automatic bit is_err_addr(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  // Reference model: outcome of each command is decided when it is pushed.
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    rsp_t e;
    xfer_t x;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (n = 0; n < 500; n++) begin
      @(negedge Hclk);
      if (bus.cmd_ready) break;
    end
    if (n == 500) begin
      fail_now("cmd_ready_wait");
      bus.cmd_valid = 1'b0;
      return;
    end
    e.write = w;
    e.err   = is_err_addr(a);
    if (w) begin
      e.rdata = 32'h0;
      if (!e.err) ref_mem[a[5:2]] = d;
    end else begin
      e.rdata = e.err ? 32'h0 : ref_mem[a[5:2]];
    end
    x.addr  = a;
    x.write = w;
    x.wdata = w ? d : 32'h0;
    exp_q.push_back(e);
    bus_q.push_back(x);
    @(posedge Hclk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    for (n = 0; n < max_cyc; n++) begin
      step();
      if (exp_q.size() == 0 && !busy && !bus.rsp_valid) break;
    end
    if (n == max_cyc) fail_now("drain_wait");
  endtask

  // Behavioural AHB slave with wait states, two-cycle ERROR and a stall mode.
  logic        s_dp_active, s_dp_write, s_last_ready, s_last_write, s_err_first;
  logic [31:0] s_dp_addr, s_dp_wdata, s_last_addr;
  logic [1:0]  s_last_trans;
  int          s_waits, s_err_step;
  initial begin
    xfer_t x;
    bus.Hreadyout = 1'b1;
    bus.Hresp = 2'b00;
    bus.Hrdata = '0;
    s_dp_active = 0; s_dp_write = 0; s_last_ready = 1; s_last_write = 0; s_err_first = 0;
    s_dp_addr = 0; s_dp_wdata = 0; s_last_addr = 0; s_last_trans = 2'b00;
    s_waits = 0; s_err_step = 0;
    forever begin
      @(posedge Hclk);
      cyc++;
      if (!Hresetn) begin
        s_dp_active = 0; s_last_ready = 1; s_last_trans = 2'b00; s_err_step = 0; s_err_first = 0;
      end else if (s_last_ready) begin
        s_dp_active = 0;
        if (s_last_trans == 2'b10) begin
          n_accepted++;
          acc_times.push_back(cyc);
          if (bus_q.size() == 0) begin
            fail_now("unexpected_transfer");
          end else begin
            x = bus_q.pop_front();
            check("xfer_addr", s_last_addr, x.addr);
            check("xfer_write", s_last_write, x.write);
            s_dp_active = 1;
            s_dp_addr = s_last_addr;
            s_dp_write = s_last_write;
            s_dp_wdata = x.wdata;
            s_err_step = is_err_addr(s_last_addr) ? 1 : 0;
            s_waits = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 2));
          end
        end
      end
      #1;
      if (Hresetn) begin
        if (!s_last_ready && s_last_trans == 2'b10 && !s_err_first) begin
          check("htrans_hold", bus.Htrans, 2'b10);
          check("haddr_hold", bus.Haddr, s_last_addr);
          check("hwrite_hold", bus.Hwrite, s_last_write);
        end
        s_err_first = 0;
        if (!s_dp_active) begin
          bus.Hreadyout = 1'b1; bus.Hresp = 2'b00; bus.Hrdata = $urandom;
        end else begin
          check("hwdata", bus.Hwdata, s_dp_write ? s_dp_wdata : 32'h0);
          if (s_err_step == 1) begin
            bus.Hreadyout = 1'b0; bus.Hresp = 2'b01; bus.Hrdata = '0;
            s_err_first = 1;
            s_err_step = 2;
          end else if (s_err_step == 2) begin
            check("err_withdraw_htrans", bus.Htrans, 2'b00);
            bus.Hreadyout = 1'b1; bus.Hresp = 2'b01; bus.Hrdata = '0;
          end else if (force_stall || s_waits > 0) begin
            bus.Hreadyout = 1'b0; bus.Hresp = 2'b00; bus.Hrdata = $urandom;
            if (!force_stall) s_waits--;
          end else begin
            bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
            if (s_dp_write) begin
              slv_mem[s_dp_addr[5:2]] = bus.Hwdata;
              bus.Hrdata = $urandom;
            end else begin
              bus.Hrdata = slv_mem[s_dp_addr[5:2]];
            end
          end
        end
        s_last_ready = bus.Hreadyout;
        s_last_trans = bus.Htrans;
        s_last_addr  = bus.Haddr;
        s_last_write = bus.Hwrite;
      end else begin
        bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
        s_last_ready = 1; s_last_trans = 2'b00;
      end
    end
  end

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge Hclk);
      #1;
      case (rsp_mode)
        0: bus.rsp_ready = 1'b0;
        1: bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Response monitor / scoreboard
  initial begin
    rsp_t e;
    forever begin
      @(negedge Hclk);
      if (Hresetn && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_write", bus.rsp_write, e.write);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      slv_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    ref_mem[8] = 32'h1234_5678;
    slv_mem[8] = 32'h1234_5678;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h8000_0000;
    bus.cmd_wdata = 32'h1111_1111;
    rsp_mode = 1;

    repeat (3) step();
    check("rst_htrans", bus.Htrans, 2'b00);
    check("rst_haddr", bus.Haddr, 32'h0);
    check("rst_hwdata", bus.Hwdata, 32'h0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    bus.cmd_valid = 1'b0;
    Hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", bus.Htrans, 2'b00);
    end

    fixed_waits = 2;
    push_cmd(1'b1, 32'h8000_0001, 32'hA5A5_A5A5);
    check("wr_htrans", bus.Htrans, 2'b10);
    check("wr_haddr", bus.Haddr, 32'h8000_0001);
    check("wr_hwrite", bus.Hwrite, 1'b1);
    wait_idle(50);

    push_cmd(1'b0, 32'h8000_00A2, 32'h0);
    check("rd_hwrite", bus.Hwrite, 1'b0);
    wait_idle(50);

    fixed_waits = 0;
    push_cmd(1'b0, 32'h8000_0004, 32'h0);
    check("lat_htrans_n1", bus.Htrans, 2'b10);
    step();
    check("lat_rsp_valid_n2", bus.rsp_valid, 1'b0);
    step();
    check("lat_rsp_valid_n3", bus.rsp_valid, 1'b1);
    wait_idle(50);

    acc_times.delete();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h8000_0040 + 32'(i * 4), $urandom);
    wait_idle(50);
    check("pipe_count", acc_times.size(), 4);
    if (acc_times.size() == 4) check("pipe_span", acc_times[3] - acc_times[0], 3);

    rsp_mode = 0;
    base = n_accepted;
    for (int i = 0; i < 6; i++) push_cmd(1'b1, 32'h8000_0000 + 32'(i * 4), $urandom);
    repeat (10) step();
    check("credit_accepted", n_accepted - base, 4);
    check("credit_htrans_idle", bus.Htrans, 2'b00);
    check("credit_cmd_ready", bus.cmd_ready, 1'b1);
    check("credit_busy", busy, 1'b1);
    push_cmd(1'b0, 32'h8000_0008, 32'h0);
    push_cmd(1'b0, 32'h8000_0000, 32'h0);
    repeat (3) step();
    check("full_cmd_ready", bus.cmd_ready, 1'b0);
    check("full_accepted", n_accepted - base, 4);
    rsp_mode = 1;
    wait_idle(200);
    check("credit_total", n_accepted - base, 8);

    push_cmd(1'b0, 32'hE000_0010, 32'h0);
    push_cmd(1'b0, 32'h8000_0014, 32'h0);
    wait_idle(50);

    rsp_mode = 2;
    fixed_waits = -1;
    for (int i = 0; i < 200; i++) begin
      a = (($urandom_range(0, 9) == 0) ? 32'hE000_0000 : 32'h8000_0000) | (32'($urandom_range(0, 15)) << 2);
      push_cmd($urandom_range(0, 1) == 1, a, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle(3000);

    rsp_mode = 1;
    force_stall = 1;
    push_cmd(1'b1, 32'h8000_0020, 32'hDEAD_BEEF);
    step();
    repeat (63) step();
    check("to_before_limit", timeout_err, 1'b0);
    step();
    check("to_at_limit", timeout_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_cleared", timeout_err, 1'b0);
    check("to_busy", busy, 1'b1);
    repeat (70) step();
    check("to_reset_again", timeout_err, 1'b1);
    Hresetn = 1'b0;
    #1;
    check("mid_rst_htrans", bus.Htrans, 2'b00);
    check("mid_rst_haddr", bus.Haddr, 32'h0);
    check("mid_rst_hwrite", bus.Hwrite, 1'b0);
    check("mid_rst_hwdata", bus.Hwdata, 32'h0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("mid_rst_rsp_err", bus.rsp_err, 1'b0);
    check("mid_rst_rsp_write", bus.rsp_write, 1'b0);
    check("mid_rst_timeout_err", timeout_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    exp_q.delete();
    bus_q.delete();
    force_stall = 0;
    step();
    step();
    Hresetn = 1'b1;
    step();

    fixed_waits = 1;
    push_cmd(1'b1, 32'h8000_0030, 32'h0BAD_F00D);
    push_cmd(1'b0, 32'h8000_0030, 32'h0);
    wait_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
